// File: rtl/h264_pkg.sv
// Shared types, entry indices and helpers for the CAVLC neighbour nC store.
package h264_pkg;

    typedef logic [4:0] nc_t;

    localparam int unsigned NC_W     = 5;

    // Current-MB array layout: luma y*4+x, Cb 16+y*2+x, Cr 20+y*2+x.
    localparam int unsigned IDX_LUMA = 0;
    localparam int unsigned IDX_CB   = 16;
    localparam int unsigned IDX_CR   = 20;
    localparam int unsigned CUR_N    = 24;

    // Left store layout: luma row y, Cb 4+y, Cr 6+y.
    localparam int unsigned LEFT_CB  = 4;
    localparam int unsigned LEFT_CR  = 6;
    localparam int unsigned LEFT_N   = 8;

    // topword field offsets: luma x at 5x, Cb x at 20+5x, Cr x at 30+5x.
    localparam int unsigned TW_W     = 40;
    localparam int unsigned TW_LUMA  = 0;
    localparam int unsigned TW_CB    = 20;
    localparam int unsigned TW_CR    = 30;

    // Rounded average of two counts; the 6-bit sum cannot overflow.
    function automatic nc_t nc_avg(input nc_t a, input nc_t b);
        logic [5:0] s;
        s = 6'(a) + 6'(b) + 6'd1;
        return s[5:1];
    endfunction

    // Current-MB array index for a block address.
    function automatic logic [4:0] cur_idx(input logic [2:0] nx, input logic [2:0] ny);
        if (!nx[2]) begin
            return {1'b0, ny[1:0], nx[1:0]};
        end
        return 5'(IDX_CB) + {2'b00, nx[1], ny[0], nx[0]};
    endfunction

endpackage

// File: rtl/h264nc_topline.sv
// Top line memory: one write port, one registered read port.
// Data words carry no reset so they can sit in block RAM; a per-word valid
// bit makes never-written words read back as zero.
module h264nc_topline #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned DW    = 40
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;

    // Data array write.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Per-word written flags.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_waddr] <= 1'b1;
        end
    end

    // Registered read.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_valid[i_raddr] ? r_mem[i_raddr] : '0;
        end
    end

endmodule

// File: rtl/h264ncstore.sv
// Neighbour non-zero-count store: records CAVLC total coefficients per block
// and predicts nC for the next block from left/top neighbours.
module h264ncstore
    import h264_pkg::*;
#(
    parameter int unsigned MAXMBX = 64
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       NEWSLICE,
    input  logic       NEWLINE,
    input  logic       NLOAD,
    input  logic [2:0] NX,
    input  logic [2:0] NY,
    input  logic [1:0] NV,
    input  logic       NXINC,
    input  logic [4:0] NOUT,
    output logic [4:0] NIN
);

    localparam int unsigned XW = (MAXMBX > 1) ? $clog2(MAXMBX) : 1;

    logic [XW-1:0]   r_mbx;
    nc_t             r_cur  [CUR_N];
    nc_t             r_left [LEFT_N];
    nc_t             r_nin;

    nc_t             w_fwd  [CUR_N];
    logic [4:0]      w_wr_idx;
    logic [TW_W-1:0] w_topword;
    logic [TW_W-1:0] w_top_wdata;
    nc_t             w_left;
    nc_t             w_top;
    nc_t             w_nc;

    assign w_wr_idx = cur_idx(NX, NY);
    assign NIN      = r_nin;

    // Current-MB view with this cycle's NOUT forwarded into its entry.
    always_comb begin
        w_fwd = r_cur;
        if (NLOAD) begin
            w_fwd[w_wr_idx] = NOUT;
        end
    end

    // Bottom-row counts committed to the line memory at end of MB.
    assign w_top_wdata = {w_fwd[IDX_CR+3],   w_fwd[IDX_CR+2],
                          w_fwd[IDX_CB+3],   w_fwd[IDX_CB+2],
                          w_fwd[IDX_LUMA+15], w_fwd[IDX_LUMA+14],
                          w_fwd[IDX_LUMA+13], w_fwd[IDX_LUMA+12]};

    h264nc_topline #(
        .DEPTH (MAXMBX),
        .AW    (XW),
        .DW    (TW_W)
    ) u_topline (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .i_we    (NXINC),
        .i_waddr (r_mbx),
        .i_wdata (w_top_wdata),
        .i_raddr (r_mbx),
        .o_rdata (w_topword)
    );

    // Neighbour selection and nC prediction.
    always_comb begin
        w_left = '0;
        w_top  = '0;
        w_nc   = '0;
        if (NX[2]) begin
            if (NX[0]) begin
                w_left = w_fwd[cur_idx({NX[2:1], 1'b0}, NY)];
            end else begin
                w_left = r_left[3'(LEFT_CB) + {1'b0, NX[1], NY[0]}];
            end
            if (NY[0]) begin
                w_top = w_fwd[cur_idx(NX, 3'b000)];
            end else begin
                w_top = w_topword[6'(TW_CB) + (NX[1] ? 6'd10 : 6'd0)
                                  + (NX[0] ? 6'd5 : 6'd0) +: NC_W];
            end
        end else begin
            if (NX[1:0] != 2'd0) begin
                w_left = w_fwd[cur_idx({1'b0, NX[1:0] - 2'd1}, NY)];
            end else begin
                w_left = r_left[{1'b0, NY[1:0]}];
            end
            if (NY[1:0] != 2'd0) begin
                w_top = w_fwd[cur_idx(NX, {1'b0, NY[1:0] - 2'd1})];
            end else begin
                w_top = w_topword[6'(TW_LUMA) + 6'({NX[1:0], 2'b00})
                                  + 6'(NX[1:0]) +: NC_W];
            end
        end
        case (NV)
            2'd1:    w_nc = w_left;
            2'd2:    w_nc = w_top;
            2'd3:    w_nc = nc_avg(w_left, w_top);
            default: w_nc = '0;
        endcase
    end

    // Registered nC output.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_nin <= '0;
        end else begin
            r_nin <= w_nc;
        end
    end

    // Current-MB array: block writes, cleared at slice start.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_cur <= '{default: '0};
        end else if (NEWSLICE) begin
            r_cur <= '{default: '0};
        end else if (NLOAD) begin
            r_cur[w_wr_idx] <= NOUT;
        end
    end

    // Left store: right column of the finished MB.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_left <= '{default: '0};
        end else if (NEWSLICE) begin
            r_left <= '{default: '0};
        end else if (NXINC) begin
            r_left[0]         <= w_fwd[IDX_LUMA+3];
            r_left[1]         <= w_fwd[IDX_LUMA+7];
            r_left[2]         <= w_fwd[IDX_LUMA+11];
            r_left[3]         <= w_fwd[IDX_LUMA+15];
            r_left[LEFT_CB]   <= w_fwd[IDX_CB+1];
            r_left[LEFT_CB+1] <= w_fwd[IDX_CB+3];
            r_left[LEFT_CR]   <= w_fwd[IDX_CR+1];
            r_left[LEFT_CR+1] <= w_fwd[IDX_CR+3];
        end
    end

    // Macroblock X counter: slice > line > end-of-MB.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_mbx <= '0;
        end else if (NEWSLICE || NEWLINE) begin
            r_mbx <= '0;
        end else if (NXINC) begin
            r_mbx <= (r_mbx == XW'(MAXMBX - 1)) ? '0 : r_mbx + XW'(1);
        end
    end

    // Flag a line longer than the line memory.
    always_ff @(posedge CLK) begin
        assert (!(RESETN && NXINC && !NEWSLICE && !NEWLINE && r_mbx == XW'(MAXMBX - 1)))
            else $error("h264ncstore: mbx overflow at MAXMBX-1, wrapping to 0");
    end

endmodule

// File: tb/tb_h264ncstore.sv
// Directed bench for the neighbour nC store.
module tb_h264ncstore;

    logic       clk;
    logic       rst_n;
    logic       newslice;
    logic       newline;
    logic       nload;
    logic [2:0] nx;
    logic [2:0] ny;
    logic [1:0] nv;
    logic       nxinc;
    logic [4:0] nout;
    logic [4:0] nin;

    int n_tests = 0;
    int n_fail  = 0;

    h264ncstore #(.MAXMBX(64)) dut (
        .CLK      (clk),
        .RESETN   (rst_n),
        .NEWSLICE (newslice),
        .NEWLINE  (newline),
        .NLOAD    (nload),
        .NX       (nx),
        .NY       (ny),
        .NV       (nv),
        .NXINC    (nxinc),
        .NOUT     (nout),
        .NIN      (nin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle block write.
    task automatic load(input logic [2:0] x, input logic [2:0] y, input logic [4:0] v);
        nx = x; ny = y; nout = v; nload = 1'b1;
        step();
        nload = 1'b0;
    endtask

    // Present a lookup and return after NIN has registered it.
    task automatic look(input logic [2:0] x, input logic [2:0] y, input logic [1:0] v);
        nx = x; ny = y; nv = v;
        step();
    endtask

    task automatic mb_end();
        nxinc = 1'b1;
        step();
        nxinc = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; newslice = 1'b0; newline = 1'b0; nload = 1'b0;
        nx = '0; ny = '0; nv = '0; nxinc = 1'b0; nout = '0;
        step(); step();
        chk("reset_nin", 8'(nin), 8'd0);
        chk("reset_mbx", 8'(dut.r_mbx), 8'd0);
        rst_n = 1'b1;
        step();

        // Empty store predicts zero.
        look(3'd0, 3'd0, 2'd3);
        chk("post_reset_avg", 8'(nin), 8'd0);

        // Intra left neighbour.
        load(3'd0, 3'd0, 5'd5);
        look(3'd1, 3'd0, 2'd1);
        chk("intra_left", 8'(nin), 8'd5);
        look(3'd1, 3'd0, 2'd0);
        chk("nv0_zero", 8'(nin), 8'd0);

        // Average rounding at luma (1,1): left (0,1), top (1,0).
        load(3'd0, 3'd1, 5'd3);
        load(3'd1, 3'd0, 5'd4);
        look(3'd1, 3'd1, 2'd3);
        chk("avg_3_4", 8'(nin), 8'd4);
        load(3'd0, 3'd1, 5'd16);
        load(3'd1, 3'd0, 5'd16);
        look(3'd1, 3'd1, 2'd3);
        chk("avg_16_16", 8'(nin), 8'd16);
        look(3'd1, 3'd1, 2'd2);
        chk("intra_top", 8'(nin), 8'd16);

        // MB boundary: right column reaches the next MB's left store.
        load(3'd3, 3'd1, 5'd7);
        mb_end();
        step();
        look(3'd0, 3'd1, 2'd1);
        chk("mb_left", 8'(nin), 8'd7);
        chk("mbx_after_inc", 8'(dut.r_mbx), 8'd1);

        // Line boundary: MB 2 bottom rows reach the next line at mbx=2.
        mb_end();
        load(3'd1, 3'd3, 5'd9);
        load(3'b111, 3'd1, 5'd2);
        mb_end();
        newline = 1'b1;
        step();
        newline = 1'b0;
        chk("mbx_newline", 8'(dut.r_mbx), 8'd0);
        mb_end();
        mb_end();
        step(); step();
        chk("mbx_two", 8'(dut.r_mbx), 8'd2);
        look(3'd1, 3'd0, 2'd2);
        chk("line_top_luma", 8'(nin), 8'd9);
        look(3'b111, 3'd0, 2'd2);
        chk("line_top_cr", 8'(nin), 8'd2);
        look(3'd1, 3'd0, 2'd3);
        chk("line_avg_5_9", 8'(nin), 8'd7);

        // NLOAD and NXINC together: commit sees the new Cr (1,1).
        nx = 3'b111; ny = 3'd1; nout = 5'd11; nload = 1'b1; nxinc = 1'b1;
        step();
        nload = 1'b0; nxinc = 1'b0;
        step();
        look(3'b110, 3'd1, 2'd1);
        chk("simul_cr_left", 8'(nin), 8'd11);

        // Slice restart clears current MB and left store.
        newslice = 1'b1; newline = 1'b1;
        step();
        newslice = 1'b0; newline = 1'b0;
        chk("mbx_newslice", 8'(dut.r_mbx), 8'd0);
        look(3'd1, 3'd0, 2'd1);
        chk("slice_cur_clear", 8'(nin), 8'd0);
        look(3'd0, 3'd1, 2'd1);
        chk("slice_left_clear", 8'(nin), 8'd0);

        // Asynchronous reset mid-MB.
        load(3'd0, 3'd0, 5'd6);
        mb_end();
        look(3'd1, 3'd0, 2'd1);
        chk("pre_reset_nin", 8'(nin), 8'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_nin", 8'(nin), 8'd0);
        chk("async_reset_mbx", 8'(dut.r_mbx), 8'd0);
        step();
        rst_n = 1'b1;
        step();
        look(3'd1, 3'd0, 2'd1);
        chk("reset_cur_clear", 8'(nin), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/h264ncstore.md
# h264ncstore

Neighbour non-zero-count store for the CAVLC stage. It sits beside `h264buffer` and the CAVLC coder. It consumes the `NLOAD`/`NX`/`NY`/`NV`/`NXINC` side channel that `h264buffer` drives, and records each coded block's total-coefficient count (`NOUT`) from CAVLC. From those records it returns the predicted count `NIN` (nC) for the next block, drawing on a per-macroblock block array, a left-column store and a top line memory.

## Interface
- `MAXMBX`, default 64: maximum macroblocks per picture line. Sets top line memory depth; the X counter is `$clog2(MAXMBX)` bits.
- `CLK`  in  1: single clock, all state on rising edge.
- `RESETN`  in  1: asynchronous, active-low reset.
- `NEWSLICE`  in  1: synchronous slice restart.
- `NEWLINE`  in  1: first macroblock of a new line follows.
- `NLOAD`  in  1: one-cycle strobe; write `NOUT` into the block addressed by `NX`/`NY` in this cycle.
- `NX`  in  3: block X. Bit 2 = 0 for luma (x = `NX[1:0]`). Bit 2 = 1 for chroma (`NX[1]` = Cb/Cr, x = `NX[0]`).
- `NY`  in  3: block Y. Luma y = `NY[1:0]`; chroma y = `NY[0]`.
- `NV`  in  2: neighbour valid flags. Bit 0 = left, bit 1 = top.
- `NXINC`  in  1: one-cycle strobe marking end of macroblock.
- `NOUT`  in  5: total coefficients of the block just coded, range 0..16.
- `NIN`  out  5: predicted nC for the block addressed by `NX`/`NY`/`NV`.

## Operation
- **Storage.**
  - Current-MB array: 16 luma entries plus 2×4 chroma entries, 5 bits each.
  - Left store: 4 luma entries plus 2×2 chroma entries.
  - Top line memory: `MAXMBX` words of 40 bits, holding 4 luma and 2×2 chroma bottom-row counts.
  - `topword`: 40-bit register caching the top line memory word for the current `mbx`.
- **Write.** When `NLOAD`=1, `NOUT` is written to the current-MB entry selected by `NX`/`NY`. Upstream guarantees `NX`/`NY` still identify the finished block in the `NLOAD` cycle.
- **Left neighbour.** If x>0, the current-MB entry at (x-1, y). If x=0, the left store entry for row y of the same component.
- **Top neighbour.** If y>0, the current-MB entry at (x, y-1). If y=0, the `topword` field for column x of the same component.
- **nC.**
  - `NV`=0: nC = 0.
  - `NV`=1: nC = left.
  - `NV`=2: nC = top.
  - `NV`=3: nC = (left+top+1)>>1, computed in 6 bits; the result is ≤16.
- **Commit on `NXINC`.**
  - Column x=3 (luma) and x=1 (each chroma) of the current MB are copied to the left store.
  - Row y=3 (luma) and y=1 (each chroma) are written to top line memory at `mbx`.
  - `mbx` increments. `topword` reloads from the new `mbx` one cycle later.
- **`NEWLINE`.** `mbx` is set to 0 and `topword` reloads. No other storage changes; `NV` gates stale data.
- **`NEWSLICE`.** `mbx` is set to 0, and the current-MB array and left store are cleared. Top memory is not cleared.
- **Simultaneous events.**
  - `NLOAD` and `NXINC` in the same cycle (last chroma AC block): the commit uses the forwarded `NOUT` for the entry being written.
  - `NLOAD` while the lookup reads the same entry: `NIN` reflects the new value (bypass).
  - `NEWSLICE` has priority over `NEWLINE`, and `NEWLINE` over `NXINC`'s `mbx` increment.
- **Boundary.** `NXINC` at `mbx`=`MAXMBX`-1 wraps `mbx` to 0 and fires a simulation `$error`.

## Timing
- `RESETN` low: `NIN`=0, `mbx`=0, all arrays and `topword` = 0, regardless of `CLK`.
- `NIN` is registered: it is valid 1 cycle after `NX`/`NY`/`NV` are presented.
- A write becomes visible to a lookup in the same cycle via bypass, so it is reflected in `NIN` on the next edge.
- `topword` is valid 1 cycle after `NXINC`/`NEWLINE`. Upstream guarantees at least 2 cycles from `NXINC` to the next `NX`/`NY` lookup with y=0.
- There are no stalls and no back-pressure; every input strobe is honoured in its cycle.

## Structure
- Shared `h264_pkg`:
  - `nc_t` (logic [4:0]).
  - Entry-index constants: luma 0..15, Cb 16..19, Cr 20..23.
  - `topword` field offsets.
  - Helper function `nc_avg`.
- Sub-module `h264nc_topline`: 40-bit × `MAXMBX` single-port-write, one-read line memory with registered read, so it can map to block RAM.

## Test plan
- Reset, then NV=3 lookup at NX=0, NY=0 → NIN=0. Assert `RESETN` mid-MB → NIN=0 immediately and `mbx`=0.
- Intra MB 0: NLOAD luma (0,0) with NOUT=5; lookup (1,0) with NV=1 → NIN=5 next cycle; lookup (1,0) with NV=0 → NIN=0.
- Average rounding: left=3 and top=4 with NV=3 → NIN=4; left=16 and top=16 → NIN=16.
- MB boundary: store luma (3,1)=7, then NXINC; next MB lookup (0,1) with NV=1 → NIN=7.
- Line boundary: MB 2 bottom row luma (1,3)=9, NXINC, NEWLINE, advance to `mbx`=2; lookup (1,0) with NV=2 → NIN=9. Chroma Cr (1,1)=2 → chroma top lookup → NIN=2.
- Simultaneous: NLOAD of Cr (1,1) with NOUT=11 in the same cycle as NXINC → next MB Cr (0,1) left lookup returns 11.
